// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RESP    = 2'd2,
      DELIVER = 2'd3
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } mem_req_t;

   localparam logic PORT_IF  = 1'b0;
   localparam logic PORT_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch (port 0) and load/store (port 1) onto one
// single-outstanding memory port, with a starvation guard and fetch-flush drop.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                       clk,
   input  logic                       async_rst,
   input  logic                       flush_if,
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [1:0][ADDR_W-1:0]     req_addr,
   input  logic [1:0]                 req_we,
   input  logic [1:0][DATA_W-1:0]     req_wdata,
   input  logic [1:0][DATA_W/8-1:0]   req_be,
   output logic [1:0]                 resp_valid,
   input  logic [1:0]                 resp_ready,
   output logic [DATA_W-1:0]          resp_rdata,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_we,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic [DATA_W/8-1:0]        mem_be,
   input  logic                       mem_resp_valid,
   input  logic [DATA_W-1:0]          mem_resp_rdata
);
   import mem_arb_pkg::*;

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   state_t              r_state;
   state_t              w_state_nxt;
   mem_req_t            r_req;
   mem_req_t            w_req_nxt;
   logic                r_owner;
   logic                w_owner_nxt;
   logic                r_drop;
   logic                w_drop_nxt;
   logic [CNT_W-1:0]    r_starve_cnt;
   logic [CNT_W-1:0]    w_starve_nxt;
   logic [DATA_W-1:0]   r_rdata;
   logic [DATA_W-1:0]   w_rdata_nxt;
   logic                r_mem_req_valid;
   logic [1:0]          r_resp_valid;

   logic                w_win0;
   logic                w_grant0;
   logic                w_grant1;
   logic                w_flush_own;
   logic                w_drop_eff;

   // Priority picker: port 1 by default, port 0 when alone or starved.
   always_comb begin
      w_win0   = req_valid[0] & ((r_starve_cnt == CNT_MAX) | ~req_valid[1]);
      w_grant0 = (r_state == IDLE) & ~async_rst & w_win0 & ~flush_if;
      w_grant1 = (r_state == IDLE) & ~async_rst & req_valid[1] & ~w_win0;
   end

   assign req_ready   = {w_grant1, w_grant0};
   assign w_flush_own = flush_if & (r_owner == PORT_IF);
   assign w_drop_eff  = r_drop | w_flush_own;

   // Next-state and next-register logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_req_nxt    = r_req;
      w_owner_nxt  = r_owner;
      w_drop_nxt   = r_drop;
      w_starve_nxt = r_starve_cnt;
      w_rdata_nxt  = r_rdata;

      case (r_state)
         IDLE: begin
            if (w_grant0 | w_grant1) begin
               w_req_nxt.addr  = req_addr[w_grant1];
               w_req_nxt.we    = req_we[w_grant1];
               w_req_nxt.wdata = req_wdata[w_grant1];
               w_req_nxt.be    = req_be[w_grant1];
               w_owner_nxt     = w_grant1 ? PORT_MEM : PORT_IF;
               w_drop_nxt      = 1'b0;
               w_state_nxt     = REQ;
            end
            if (w_grant0) begin
               w_starve_nxt = '0;
            end else if (w_grant1 && req_valid[0] && (r_starve_cnt != CNT_MAX)) begin
               w_starve_nxt = r_starve_cnt + CNT_W'(1);
            end
         end
         REQ: begin
            if (w_flush_own) begin
               w_drop_nxt = 1'b1;
            end
            if (mem_req_ready) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_drop_nxt = w_drop_eff;
            if (mem_resp_valid) begin
               w_rdata_nxt = mem_resp_rdata;
               if (w_drop_eff) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DELIVER;
               end
            end
         end
         DELIVER: begin
            if (resp_ready[r_owner] || w_flush_own) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from next-state so they line up with the state.
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         r_state         <= IDLE;
         r_req           <= '0;
         r_owner         <= PORT_IF;
         r_drop          <= 1'b0;
         r_starve_cnt    <= '0;
         r_rdata         <= '0;
         r_mem_req_valid <= 1'b0;
         r_resp_valid    <= 2'b00;
      end else begin
         r_state         <= w_state_nxt;
         r_req           <= w_req_nxt;
         r_owner         <= w_owner_nxt;
         r_drop          <= w_drop_nxt;
         r_starve_cnt    <= w_starve_nxt;
         r_rdata         <= w_rdata_nxt;
         r_mem_req_valid <= (w_state_nxt == REQ);
         r_resp_valid    <= (w_state_nxt == DELIVER) ? {w_owner_nxt, ~w_owner_nxt} : 2'b00;
      end
   end

   assign mem_req_valid = r_mem_req_valid;
   assign mem_addr      = r_req.addr;
   assign mem_we        = r_req.we;
   assign mem_wdata     = r_req.wdata;
   assign mem_be        = r_req.be;
   assign resp_valid    = r_resp_valid;
   assign resp_rdata    = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps followed by
// randomized transactions against a transaction-level arbiter/memory model.
module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              async_rst;
   logic              flush_if;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][31:0]  req_addr;
   logic [1:0]        req_we;
   logic [1:0][31:0]  req_wdata;
   logic [1:0][3:0]   req_be;
   logic [1:0]        resp_valid;
   logic [1:0]        resp_ready;
   logic [31:0]       resp_rdata;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [31:0]       mem_addr;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_resp_valid;
   logic [31:0]       mem_resp_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int starve  = 0;
   logic [31:0] mem_m [16];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .async_rst(async_rst), .flush_if(flush_if),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int mdl_win(input logic [1:0] v);
      return (v[0] && (starve == STARVE_MAX || !v[1])) ? 0 : 1;
   endfunction

   function automatic logic [1:0] onehot(input int p);
      return (p == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic rand_payload();
      for (int p = 0; p < 2; p++) begin
         req_addr[p]  = {24'h0, 2'($urandom), 4'($urandom), 2'b00};
         req_we[p]    = 1'($urandom);
         req_wdata[p] = $urandom;
         req_be[p]    = 4'($urandom);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mreqv"}, 32'(mem_req_valid), 32'h0);
      chk({tag, "_maddr"}, mem_addr, 32'h0);
      chk({tag, "_mwe"}, 32'(mem_we), 32'h0);
      chk({tag, "_mwdata"}, mem_wdata, 32'h0);
      chk({tag, "_mbe"}, 32'(mem_be), 32'h0);
      chk({tag, "_rvalid"}, 32'(resp_valid), 32'h0);
      chk({tag, "_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_rready"}, 32'(req_ready), 32'h0);
   endtask

   // fmode: 0 none, 1 flush in REQ, 2 flush in RESP, 3 flush with mem_resp_valid, 4 flush in DELIVER
   task automatic do_txn(input logic [1:0] v, input int rdy_dly, input int rsp_dly,
                         input int dlv_dly, input int fmode, input logic [1:0] pre_v,
                         output int win);
      int exp_win;
      int t;
      int idx;
      logic [31:0] rd;
      logic drop;
      exp_win = mdl_win(v);
      req_valid = v;
      #1;
      t = 0;
      while (req_ready === 2'b00 && t < 20) begin
         tick();
         t++;
      end
      chk("grant", 32'(req_ready), 32'(onehot(exp_win)));
      win = (req_ready[1] === 1'b1) ? 1 : 0;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      if (exp_win == 0) starve = 0;
      else if (v[0] && starve < STARVE_MAX) starve++;

      for (int i = 0; i <= rdy_dly; i++) begin
         chk("req_valid", 32'(mem_req_valid), 32'h1);
         chk("req_addr", mem_addr, req_addr[exp_win]);
         chk("req_we", 32'(mem_we), 32'(req_we[exp_win]));
         chk("req_wdata", mem_wdata, req_wdata[exp_win]);
         chk("req_be", 32'(mem_be), 32'(req_be[exp_win]));
         chk("req_busy", 32'(req_ready), 32'h0);
         if (fmode == 1 && i == 0) flush_if = 1'b1;
         if (i == rdy_dly) mem_req_ready = 1'b1;
         tick();
         mem_req_ready = 1'b0;
         flush_if = 1'b0;
      end

      idx = int'(req_addr[exp_win][5:2]);
      if (req_we[exp_win]) begin
         for (int b = 0; b < 4; b++)
            if (req_be[exp_win][b]) mem_m[idx][8*b +: 8] = req_wdata[exp_win][8*b +: 8];
      end
      rd = mem_m[idx];
      drop = (exp_win == 0) && (fmode >= 1 && fmode <= 3);

      for (int i = 0; i <= rsp_dly; i++) begin
         chk("resp_wait_mreq", 32'(mem_req_valid), 32'h0);
         chk("resp_wait_rv", 32'(resp_valid), 32'h0);
         if (fmode == 2 && i == 0) flush_if = 1'b1;
         if (i == rsp_dly) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rd;
            if (fmode == 3) flush_if = 1'b1;
            if (drop) req_valid = pre_v;
         end
         tick();
         mem_resp_valid = 1'b0;
         mem_resp_rdata = $urandom;
         flush_if = 1'b0;
      end

      if (drop) begin
         chk("drop_rv", 32'(resp_valid), 32'h0);
         chk("drop_idle", 32'(req_ready), (pre_v == 2'b00) ? 32'h0 : 32'(onehot(mdl_win(pre_v))));
         return;
      end

      for (int i = 0; i <= dlv_dly; i++) begin
         chk("dlv_rv", 32'(resp_valid), 32'(onehot(exp_win)));
         chk("dlv_rdata", resp_rdata, rd);
         if (fmode == 4 && i == 0) flush_if = 1'b1;
         if (i == dlv_dly) resp_ready[exp_win] = 1'b1;
         tick();
         flush_if = 1'b0;
         resp_ready = 2'b00;
         if (fmode == 4 && exp_win == 0) break;
      end
      chk("dlv_done", 32'(resp_valid), 32'h0);
   endtask

   int w;
   int seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   initial begin
      async_rst = 1'b1;
      flush_if = 1'b0;
      req_valid = 2'b11;
      resp_ready = 2'b00;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 32'h0;
      for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
      rand_payload();
      tick();
      tick();
      check_all_zero("reset");
      req_valid = 2'b00;
      async_rst = 1'b0;
      tick();

      // Port 1 read of 0x100 returning DEADBEEF two cycles after accept
      mem_m[0] = 32'hDEADBEEF;
      rand_payload();
      req_addr[1] = 32'h100;
      req_we[1] = 1'b0;
      do_txn(2'b10, 0, 1, 0, 0, 2'b00, w);
      chk("p1_only_winner", 32'(w), 32'h1);

      // Starvation guard: both requesting continuously
      for (int k = 0; k < 10; k++) begin
         rand_payload();
         do_txn(2'b11, 0, 0, 0, 0, 2'b00, w);
         chk("grant_order", 32'(w), 32'(seq[k]));
      end

      // Port 0 read stalled on mem_req_ready
      rand_payload();
      req_we[0] = 1'b0;
      do_txn(2'b01, 5, 0, 0, 0, 2'b00, w);

      // Flush in RESP drops port 0; queued port 1 granted right after
      rand_payload();
      do_txn(2'b01, 0, 2, 0, 2, 2'b10, w);
      do_txn(2'b10, 0, 0, 0, 0, 2'b00, w);

      // Flush coinciding with mem_resp_valid, and flush during REQ
      rand_payload();
      do_txn(2'b01, 1, 1, 0, 3, 2'b00, w);
      rand_payload();
      do_txn(2'b01, 1, 1, 0, 1, 2'b00, w);

      // Port 1 delivery held three cycles; flush has no effect
      rand_payload();
      do_txn(2'b10, 0, 0, 3, 4, 2'b00, w);

      // Flush in DELIVER with owner 0
      rand_payload();
      do_txn(2'b01, 0, 0, 3, 4, 2'b00, w);

      // Flush in IDLE suppresses a port 0 grant
      req_valid = 2'b01;
      flush_if = 1'b1;
      #1;
      chk("idle_flush_suppress", 32'(req_ready), 32'h0);
      flush_if = 1'b0;
      #1;
      chk("idle_noflush_grant", 32'(req_ready), 32'h1);
      req_valid = 2'b00;
      tick();

      // Async reset in REQ
      rand_payload();
      req_addr[1] = 32'h104;
      req_wdata[1] = 32'hA5A5_0001;
      req_be[1] = 4'hF;
      req_we[1] = 1'b1;
      req_valid = 2'b10;
      #1;
      chk("rst_pre_grant", 32'(req_ready), 32'h2);
      tick();
      chk("rst_pre_mreqv", 32'(mem_req_valid), 32'h1);
      #2;
      async_rst = 1'b1;
      #1;
      check_all_zero("rst_in_req");
      req_valid = 2'b00;
      @(negedge clk);
      async_rst = 1'b0;
      starve = 0;
      tick();
      rand_payload();
      do_txn(2'b10, 0, 0, 0, 0, 2'b00, w);
      chk("post_rst_winner", 32'(w), 32'h1);

      // Randomized transactions
      for (int k = 0; k < 40; k++) begin
         rand_payload();
         do_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 4), 2'b00, w);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
